apb_cmd_master: RTL and testbench

APB initiator that turns single-beat command requests (valid/ready) into APB setup/access transfers toward the peripheral register slaves in the extender (direction control, mux and reset registers). It drives `apb_sel`/`apb_ena`/`apb_addr`/`apb_wdata`/`apb_pstb`, waits on `apb_rready`, and returns read data or a timeout error on a response channel. It allows a management-side state machine or debug port to program peripheral registers without knowing APB phasing.

---
 rtl/apb_cmd_master.sv | 149 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Single-outstanding APB initiator. Accepts one command on a valid/ready
//   request channel. It runs the APB SETUP and ACCESS phases toward the
//   peripheral register slaves, then presents the read data or a timeout
//   error on a valid/ready response channel.
//
// Parameters
//   TIMEOUT  ACCESS cycles allowed before abort (0 = wait forever)
//   CNT_W    width of the ACCESS-cycle counter (TIMEOUT < 2**CNT_W)
//
// Ports
//   clock, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready      command handshake
//   req_write/addr/wdata/strb  command fields
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        read data (0 for writes/timeouts), timeout flag
//   apb_sel/ena/write/addr/wdata/pstb  APB master outputs
//   apb_rdata/apb_rready     APB slave read data and ready
module apb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] apb_addr,
  output logic        apb_sel,
  output logic        apb_write,
  output logic        apb_ena,
  output logic [31:0] apb_wdata,
  output logic [3:0]  apb_pstb,
  input  logic [31:0] apb_rdata,
  input  logic        apb_rready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_done    = (r_state == S_ACCESS) && apb_rready;
  // Slave ready has priority over the timeout in the same cycle.
  assign w_timeout = (r_state == S_ACCESS) && !apb_rready &&
                     (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // State register; reset drops sel/ena/rsp_valid immediately since they
  // are decoded from the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    apb_sel   = 1'b0;
    apb_ena   = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        apb_sel = 1'b1;
        w_next  = S_ACCESS;
      end
      S_ACCESS: begin
        apb_sel = 1'b1;
        apb_ena = 1'b1;
        if (w_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ACCESS-cycle counter: cleared in SETUP (i.e. on every entry to
  // ACCESS), saturating while in ACCESS.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == S_ACCESS) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Command capture: APB address/data outputs change only on accept, so
  // they are stable through SETUP/ACCESS and hold afterwards.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      apb_addr  <= '0;
      apb_write <= 1'b0;
      apb_wdata <= '0;
      apb_pstb  <= '0;
    end else if (w_accept) begin
      apb_addr  <= req_addr;
      apb_write <= req_write;
      apb_wdata <= req_write ? req_wdata : 32'h0;
      apb_pstb  <= req_write ? req_strb  : 4'b0000;
    end
  end

  // Response capture at the end of ACCESS; held through RESP.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (w_done) begin
      rsp_rdata <= apb_write ? 32'h0 : apb_rdata;
      rsp_err   <= 1'b0;
    end else if (w_timeout) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  logic        clock;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] apb_addr;
  logic        apb_sel;
  logic        apb_write;
  logic        apb_ena;
  logic [31:0] apb_wdata;
  logic [3:0]  apb_pstb;
  logic [31:0] apb_rdata;
  logic        apb_rready;

  int n_tests = 0;
  int n_fail  = 0;

  apb_cmd_master #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_addr   (apb_addr),
    .apb_sel    (apb_sel),
    .apb_write  (apb_write),
    .apb_ena    (apb_ena),
    .apb_wdata  (apb_wdata),
    .apb_pstb   (apb_pstb),
    .apb_rdata  (apb_rdata),
    .apb_rready (apb_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command and let it be accepted at the next edge.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = st;
    tick();
    req_valid = 1'b0;
    chk("sel_in_setup", {31'd0, apb_sel}, 32'd1);
    chk("ena_in_setup", {31'd0, apb_ena}, 32'd0);
    chk("addr_in_setup", apb_addr, addr);
    chk("write_in_setup", {31'd0, apb_write}, {31'd0, wr});
    chk("wdata_in_setup", apb_wdata, wr ? wd : 32'h0);
    chk("pstb_in_setup", {28'd0, apb_pstb}, wr ? {28'd0, st} : 32'h0);
    chk("req_ready_in_setup", {31'd0, req_ready}, 32'd0);
  endtask

  // Run ACCESS until rsp_valid. Slave is ready from ACCESS cycle stall+1;
  // stall < 0 means never ready. Returns number of cycles with apb_ena high.
  task automatic run_access(input int stall, input logic [31:0] exp_addr,
                            output int ena_cycles);
    bit got;
    ena_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (apb_ena) begin
          ena_cycles++;
          chk("addr_stable_access", apb_addr, exp_addr);
          apb_rready = (stall >= 0) && (ena_cycles > stall);
        end
        tick();
      end
    end
    apb_rready = 1'b0;
    if (!got) chk("rsp_valid_wait_bound", 32'd0, 32'd1);
    chk("sel_low_in_resp", {31'd0, apb_sel}, 32'd0);
    chk("ena_low_in_resp", {31'd0, apb_ena}, 32'd0);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  int ena;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_strb   = '0;
    rsp_ready  = 1'b1;
    apb_rdata  = '0;
    apb_rready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_sel", {31'd0, apb_sel}, 32'd0);
    chk("rst_ena", {31'd0, apb_ena}, 32'd0);
    chk("rst_write", {31'd0, apb_write}, 32'd0);
    chk("rst_addr", apb_addr, 32'd0);
    chk("rst_wdata", apb_wdata, 32'd0);
    chk("rst_pstb", {28'd0, apb_pstb}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    tick();

    // Write, slave immediately ready; read data bus carries junk.
    apb_rdata  = 32'hDEAD_BEEF;
    apb_rready = 1'b1;
    issue(1'b1, 32'h1C, 32'h1, 4'hF);
    tick();
    chk("w1_sel_access", {31'd0, apb_sel}, 32'd1);
    chk("w1_ena_access", {31'd0, apb_ena}, 32'd1);
    tick();
    apb_rready = 1'b0;
    chk("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w1_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_sel_resp", {31'd0, apb_sel}, 32'd0);
    chk("w1_pstb_hold", {28'd0, apb_pstb}, 32'hF);
    tick();
    chk("w1_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("w1_req_ready", {31'd0, req_ready}, 32'd1);

    // Read with 3 stalled ACCESS cycles (4th cycle ready, also the timeout
    // cycle for TIMEOUT=4 -> ready wins).
    apb_rdata = 32'h0000_0008;
    issue(1'b0, 32'h00, 32'hFFFF_FFFF, 4'hF);
    run_access(3, 32'h00, ena);
    chk("r2_ena_cycles", ena, 32'd4);
    chk("r2_rsp_rdata", rsp_rdata, 32'h8);
    chk("r2_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("r2_pstb", {28'd0, apb_pstb}, 32'd0);
    handshake();

    // Timeout read.
    apb_rdata = 32'h5555_5555;
    issue(1'b0, 32'h2C, 32'h0, 4'h0);
    run_access(-1, 32'h2C, ena);
    chk("to_ena_cycles", ena, 32'd4);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    handshake();

    // Next command after timeout completes normally.
    issue(1'b1, 32'h30, 32'hA5A5_0001, 4'h3);
    run_access(0, 32'h30, ena);
    chk("post_to_ena_cycles", ena, 32'd1);
    chk("post_to_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("post_to_rsp_rdata", rsp_rdata, 32'd0);
    handshake();

    // Response back-pressure with a second request pending.
    apb_rdata = 32'h0000_1234;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    run_access(0, 32'h04, ena);
    apb_rdata = 32'h0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h08;
    req_wdata = 32'h0000_00C3;
    req_strb  = 4'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_second_sel", {31'd0, apb_sel}, 32'd1);
    chk("bp_second_addr", apb_addr, 32'h08);
    chk("bp_second_wdata", apb_wdata, 32'hC3);
    run_access(0, 32'h08, ena);
    chk("bp_second_err", {31'd0, rsp_err}, 32'd0);
    handshake();

    // Reset asserted during ACCESS of a write.
    issue(1'b1, 32'h1C, 32'h0000_00AA, 4'hF);
    tick();
    chk("rst_mid_in_access", {31'd0, apb_ena}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", {31'd0, apb_sel}, 32'd0);
    chk("rst_mid_ena", {31'd0, apb_ena}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_addr", apb_addr, 32'd0);
    chk("rst_mid_wdata", apb_wdata, 32'd0);
    chk("rst_mid_pstb", {28'd0, apb_pstb}, 32'd0);
    chk("rst_mid_write", {31'd0, apb_write}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    end

    // Following read works normally.
    apb_rdata = 32'h0000_0077;
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    run_access(1, 32'h0C, ena);
    chk("post_rst_ena_cycles", ena, 32'd2);
    chk("post_rst_rdata", rsp_rdata, 32'h77);
    chk("post_rst_err", {31'd0, rsp_err}, 32'd0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
